// File: rtl/mod_capture_if.sv
// Stream-in and show-ahead read-port bundle for mod_capture.
// master = producer/reader side, slave = capture endpoint.
interface mod_capture_if #(
  parameter int unsigned WIDTH = 32
);
  logic             i_valid;
  logic [WIDTH-1:0] i_data;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic             i_ready;

  modport master (
    output i_valid,
    output i_data,
    output i_ready,
    input  o_valid,
    input  o_data
  );

  modport slave (
    input  i_valid,
    input  i_data,
    input  i_ready,
    output o_valid,
    output o_data
  );
endinterface

// File: rtl/mod_capture.sv
// Capture endpoint: show-ahead FIFO on a no-backpressure stream plus capture statistics.
// Optional running checksum enabled by defining MOD_CAPTURE_CHECKSUM_EN.
module mod_capture #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_x,
  input  logic                  i_clr,
  mod_capture_if.slave          bus,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic [15:0]           o_count,
  output logic [7:0]            o_drop,
  output logic                  o_overflow,
  output logic [WIDTH-1:0]      o_checksum
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned PW    = DEPTH_LOG2;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic [15:0]      r_count;
  logic [7:0]       r_drop;
  logic             r_overflow;

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Handshake qualifiers; a full FIFO still accepts when the head leaves this cycle.
  assign w_valid = (r_level != '0);
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_pop   = w_valid && bus.i_ready;
  assign w_push  = bus.i_valid && (!w_full || w_pop);
  assign w_drop  = bus.i_valid && w_full && !w_pop;

  // Storage array is deliberately unreset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push && !i_clr) begin
      r_mem[r_wptr] <= bus.i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Statistics: accepted count wraps, drop count saturates, overflow is sticky.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_count    <= '0;
      r_drop     <= '0;
      r_overflow <= 1'b0;
    end else if (i_clr) begin
      r_count    <= '0;
      r_drop     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_count <= r_count + 16'd1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      end
    end
  end

`ifdef MOD_CAPTURE_CHECKSUM_EN
  logic [WIDTH-1:0] r_checksum;

  // Rotate-left-1 then XOR each accepted word.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_checksum <= '0;
    end else if (i_clr) begin
      r_checksum <= '0;
    end else if (w_push) begin
      r_checksum <= {r_checksum[WIDTH-2:0], r_checksum[WIDTH-1]} ^ bus.i_data;
    end
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = '0;
`endif

  assign bus.o_valid = w_valid;
  assign bus.o_data  = w_valid ? r_mem[r_rptr] : '0;
  assign o_level     = r_level;
  assign o_count     = r_count;
  assign o_drop      = r_drop;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_mod_capture.sv
// Directed self-checking bench for mod_capture: FIFO order, full/drop rules, clear, reset, checksum.
module tb_mod_capture;

  logic        clk;
  logic        rst_x;
  logic        i_clr;
  logic [3:0]  o_level;
  logic [15:0] o_count;
  logic [7:0]  o_drop;
  logic        o_overflow;
  logic [31:0] o_checksum;

  int n_tests;
  int n_fail;
  logic [31:0] m_ck;

  mod_capture_if #(.WIDTH(32)) bus ();

  mod_capture #(.DEPTH_LOG2(3), .WIDTH(32)) dut (
    .clk        (clk),
    .rst_x      (rst_x),
    .i_clr      (i_clr),
    .bus        (bus.slave),
    .o_level    (o_level),
    .o_count    (o_count),
    .o_drop     (o_drop),
    .o_overflow (o_overflow),
    .o_checksum (o_checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ck_next(input logic [31:0] prev, input logic [31:0] d);
    return {prev[30:0], prev[31]} ^ d;
  endfunction

  function automatic logic [31:0] ck_exp();
`ifdef MOD_CAPTURE_CHECKSUM_EN
    return m_ck;
`else
    return 32'h0;
`endif
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_ck    = 32'h0;
    rst_x = 1'b0;
    i_clr = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = 32'h0;
    bus.i_ready = 1'b0;

    // Reset then idle
    repeat (3) tick();
    rst_x = 1'b1;
    tick();
    chk("rst_valid", 32'(bus.o_valid), 32'h0);
    chk("rst_data", bus.o_data, 32'h0);
    chk("rst_level", 32'(o_level), 32'h0);
    chk("rst_count", 32'(o_count), 32'h0);
    chk("rst_drop", 32'(o_drop), 32'h0);
    chk("rst_ovf", 32'(o_overflow), 32'h0);
    chk("rst_ck", o_checksum, 32'h0);

    // Single word, visible next cycle, then popped
    bus.i_valid = 1'b1; bus.i_data = 32'h1234_5678;
    tick();
    m_ck = ck_next(m_ck, 32'h1234_5678);
    bus.i_valid = 1'b0;
    chk("single_valid", 32'(bus.o_valid), 32'h1);
    chk("single_data", bus.o_data, 32'h1234_5678);
    chk("single_level", 32'(o_level), 32'h1);
    chk("single_count", 32'(o_count), 32'h1);
    chk("single_ck", o_checksum, ck_exp());
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    chk("single_pop_level", 32'(o_level), 32'h0);
    chk("single_pop_valid", 32'(bus.o_valid), 32'h0);
    chk("single_pop_data", bus.o_data, 32'h0);

    // Fill and overflow: 11 writes, 8 stored, 3 dropped
    i_clr = 1'b1; tick(); i_clr = 1'b0; m_ck = 32'h0;
    for (int i = 0; i < 11; i++) begin
      bus.i_valid = 1'b1; bus.i_data = 32'(i);
      tick();
      if (i < 8) m_ck = ck_next(m_ck, 32'(i));
    end
    bus.i_valid = 1'b0;
    chk("fill_level", 32'(o_level), 32'h8);
    chk("fill_count", 32'(o_count), 32'h8);
    chk("fill_drop", 32'(o_drop), 32'h3);
    chk("fill_ovf", 32'(o_overflow), 32'h1);
    chk("fill_ck", o_checksum, ck_exp());
    bus.i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain_%0d", k), bus.o_data, 32'(k));
      tick();
    end
    bus.i_ready = 1'b0;
    chk("drain_valid", 32'(bus.o_valid), 32'h0);
    chk("drain_level", 32'(o_level), 32'h0);
    chk("drain_ovf_sticky", 32'(o_overflow), 32'h1);

    // Full with simultaneous push and pop
    i_clr = 1'b1; tick(); i_clr = 1'b0; m_ck = 32'h0;
    for (int i = 0; i < 8; i++) begin
      bus.i_valid = 1'b1; bus.i_data = 32'h10 + 32'(i);
      tick();
      m_ck = ck_next(m_ck, 32'h10 + 32'(i));
    end
    bus.i_data = 32'hAA; bus.i_ready = 1'b1;
    chk("pp_head", bus.o_data, 32'h10);
    tick();
    m_ck = ck_next(m_ck, 32'hAA);
    bus.i_valid = 1'b0;
    chk("pp_level", 32'(o_level), 32'h8);
    chk("pp_count", 32'(o_count), 32'h9);
    chk("pp_drop", 32'(o_drop), 32'h0);
    chk("pp_ovf", 32'(o_overflow), 32'h0);
    chk("pp_ck", o_checksum, ck_exp());
    for (int k = 1; k < 8; k++) begin
      chk($sformatf("pp_drain_%0d", k), bus.o_data, 32'h10 + 32'(k));
      tick();
    end
    chk("pp_drain_aa", bus.o_data, 32'hAA);
    tick();
    bus.i_ready = 1'b0;
    chk("pp_empty", 32'(o_level), 32'h0);

    // Clear priority: 5 buffered, 2 dropped, clr with valid and ready
    for (int i = 0; i < 10; i++) begin
      bus.i_valid = 1'b1; bus.i_data = 32'h20 + 32'(i);
      tick();
    end
    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    repeat (3) tick();
    bus.i_ready = 1'b0;
    chk("pre_clr_level", 32'(o_level), 32'h5);
    chk("pre_clr_drop", 32'(o_drop), 32'h2);
    chk("pre_clr_head", bus.o_data, 32'h23);
    i_clr = 1'b1; bus.i_valid = 1'b1; bus.i_data = 32'hDEAD; bus.i_ready = 1'b1;
    tick();
    i_clr = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b0; m_ck = 32'h0;
    chk("clr_level", 32'(o_level), 32'h0);
    chk("clr_count", 32'(o_count), 32'h0);
    chk("clr_drop", 32'(o_drop), 32'h0);
    chk("clr_ovf", 32'(o_overflow), 32'h0);
    chk("clr_valid", 32'(bus.o_valid), 32'h0);
    chk("clr_ck", o_checksum, 32'h0);
    tick();
    chk("clr_after_count", 32'(o_count), 32'h0);

    // Ready while empty moves nothing
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    chk("rdy_empty_level", 32'(o_level), 32'h0);

    // Checksum sequence
    bus.i_valid = 1'b1; bus.i_data = 32'h0000_0001;
    tick();
    m_ck = 32'h0000_0001;
    chk("ck_first", o_checksum, ck_exp());
    bus.i_data = 32'h8000_0000;
    tick();
    m_ck = 32'h8000_0002;
    bus.i_valid = 1'b0;
    chk("ck_second", o_checksum, ck_exp());
    chk("ck_level", 32'(o_level), 32'h2);
    chk("ck_head", bus.o_data, 32'h1);

    // Drop counter saturation with 6 more stored and 260 dropped
    for (int i = 0; i < 266; i++) begin
      bus.i_valid = 1'b1; bus.i_data = 32'h100 + 32'(i);
      tick();
      if (i < 6) m_ck = ck_next(m_ck, 32'h100 + 32'(i));
    end
    bus.i_valid = 1'b0;
    chk("sat_drop", 32'(o_drop), 32'hFF);
    chk("sat_count", 32'(o_count), 32'h8);
    chk("sat_level", 32'(o_level), 32'h8);
    chk("sat_ck", o_checksum, ck_exp());

    // Asynchronous reset mid-stream
    #2 rst_x = 1'b0;
    #1;
    chk("arst_level", 32'(o_level), 32'h0);
    chk("arst_valid", 32'(bus.o_valid), 32'h0);
    chk("arst_data", bus.o_data, 32'h0);
    chk("arst_drop", 32'(o_drop), 32'h0);
    chk("arst_ovf", 32'(o_overflow), 32'h0);
    chk("arst_ck", o_checksum, 32'h0);
    rst_x = 1'b1;
    tick();
    chk("arst_count", 32'(o_count), 32'h0);
    chk("arst_idle_valid", 32'(bus.o_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
